m_matrix_arbiter_pkt_lock: RTL and testbench
============================================

// Module: m_matrix_arbiter_pkt_lock
// PURPOSE
//  N-requester matrix arbiter with wormhole packet lock, one instance per router output port.
//  Keeps an N x N least-recently-served priority matrix and issues a one-hot grant in the
//  same cycle as the request.
//  Holds the grant on one requester from its head flit up to and including its tail flit.
//  The switch allocator uses it to share one output port and crossbar column between input ports.
// PARAMETERS
//  N       5   number of requesters (router input ports); legal range 2..16
//  ID_W    3   width of gnt_id; must be >= clog2(N)
// PORTS
//  CLK      in   1     clock, all state updates on rising edge
//  RST      in   1     synchronous reset, active-high
//  req      in   N     per-requester flit request; bit i = input port i has a flit for this output
//  tail     in   N     per-requester tail marker, qualified by req[i]; single-flit packet has tail=1
//  en       in   1     output able to accept a flit this cycle (downstream credit available)
//  gnt      out  N     one-hot grant, combinational from req/tail/en/state; all-zero if no grant
//  gnt_vld  out  1     |gnt
//  gnt_id   out  ID_W  binary index of granted requester; 0 when gnt_vld=0
//  locked   out  1     registered: a packet currently owns the output
// BEHAVIOUR
//  State:
//   - W[i][j] for i<j (N(N-1)/2 flops); W[i][j]=1 means i beats j, and W[j][i] is defined as ~W[i][j].
//   - lock_vld (1 bit) and lock_id (ID_W bits).
//  Reset (RST=1 at a CLK edge):
//   - W[i][j]=1 for all i<j, so index 0 has highest priority.
//   - lock_vld=0, lock_id=0.
//   - While RST=1, gnt, gnt_vld and gnt_id are forced to 0. locked reads 0 from the first edge after RST is sampled.
//  Unlocked (lock_vld=0):
//   - Candidate i = req[i] & ~(OR over j!=i of req[j] & W[j][i]). The result is at most one-hot by construction.
//   - gnt = candidate & {N{en}}.
//  Locked (lock_vld=1):
//   - gnt[lock_id] = req[lock_id] & en. All other gnt bits are 0 and other requesters are ignored.
//   - If the owner drops req mid-packet, gnt=0 and the lock is held, so no other packet can interleave.
//  State update on a grant to requester k, i.e. gnt[k]=1 at an edge:
//   - tail[k]=0:
//     - lock_vld<=1, lock_id<=k.
//     - Matrix unchanged.
//   - tail[k]=1:
//     - lock_vld<=0.
//     - Matrix update makes k lowest priority: W[k][j]<=0 and W[j][k]<=1 for all j!=k.
//     - Only the N-1 entries involving k change.
//  No grant in a cycle (en=0 or no eligible req): all state holds.
//  Arbitration latency: 0 cycles, request to grant in the same cycle. Matrix update is visible in the next cycle.
//  Fairness: a packet that has just finished drops below every other requester.
//   - Any continuously requesting input is served within N-1 packets.
//  Simultaneous events:
//   - Head and tail in the same flit releases immediately; lock never set.
//   - en=0 while locked: no grant, lock held.
//  Reset mid-packet clears the lock and restores the initial priority; the packet remnant is the upstream's concern.
//  Invariant, for assertions: gnt is one-hot or zero; gnt implies en; when lock_vld=1, gnt & ~(1<<lock_id) == 0.
// TESTING
//  1 After RST, req=5'b10110, tail=all 1, en=1 -> gnt=5'b00010, gnt_id=1. Next cycle, same req -> gnt=5'b00100.
//  2 req=5'b11111 held with tail=all 1 for 5 cycles -> grants 0,1,2,3,4 in order, and 6th cycle grants 0 again.
//  3 Lock hold: req[2] head (tail=0), then req[0] asserted.
//    -> gnt stays 5'b00100 with locked=1 through the 3-flit packet.
//    -> req[0] is granted in the cycle after port 2's tail.
//  4 Bubble: owner port 1 drops req mid-packet for 2 cycles while req[3]=1.
//    -> gnt=0 and locked=1 for both cycles.
//    -> port 1 resumes and is granted.
//  5 en=0 for 3 cycles with req=5'b00011 -> gnt=0, no state change. en=1 -> gnt=5'b00001.
//  6 RST asserted while locked on port 4 -> next cycle locked=0; req=5'b10001 -> gnt=5'b00001.

Source files
------------

// File: rtl/m_matrix_arbiter_pkt_lock.sv
// m_matrix_arbiter_pkt_lock: N-way least-recently-served matrix arbiter with wormhole packet lock.
// Grants combinationally; a head flit locks the output until the same requester's tail flit.
module m_matrix_arbiter_pkt_lock #(
    parameter int N    = 5,
    parameter int ID_W = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    tail,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic            gnt_vld,
    output logic [ID_W-1:0] gnt_id,
    output logic            locked
);
    localparam int P = N * (N - 1) / 2;

    // Upper triangle only: entry for (i,j), i<j, stores "i beats j".
    function automatic int pidx(input int i, input int j);
        return i * N - (i * (i + 1)) / 2 + j - i - 1;
    endfunction

    logic [P-1:0]          tri_q, tri_d;
    logic                  lock_vld_q, lock_vld_d;
    logic [ID_W-1:0]       lock_id_q, lock_id_d;
    logic [N-1:0][N-1:0]   beats;
    logic [N-1:0]          lose, cand, own;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tri_q      <= '1;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else begin
            tri_q      <= tri_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    always_comb begin
        beats = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                beats[i][j] = (i == j) ? 1'b0 : (i < j) ? tri_q[pidx(i, j)] : ~tri_q[pidx(j, i)];
    end

    always_comb begin
        lose = '0;
        own  = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++)
                lose[i] = lose[i] | (req[j] & beats[j][i]);
            own[i] = (lock_id_q == ID_W'(i));
        end
        cand = req & ~lose;
    end

    always_comb begin
        gnt = RST ? '0 : lock_vld_q ? (req & own & {N{en}}) : (cand & {N{en}});
        gnt_vld = |gnt;
        gnt_id = '0;
        for (int i = 0; i < N; i++)
            gnt_id = gnt[i] ? ID_W'(i) : gnt_id;
        locked = lock_vld_q;
    end

    // A tail grant pushes the winner below everyone; a head-only grant locks without touching priority.
    always_comb begin
        lock_vld_d = gnt_vld ? ~|(gnt & tail) : lock_vld_q;
        lock_id_d  = gnt_vld ? gnt_id : lock_id_q;
        tri_d      = tri_q;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                tri_d[pidx(i, j)] = (gnt[i] & tail[i]) ? 1'b0 :
                                    (gnt[j] & tail[j]) ? 1'b1 : tri_q[pidx(i, j)];
    end

    a_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(gnt));
    a_en:     assert property (@(posedge CLK) disable iff (RST) gnt_vld |-> en);
    a_lock:   assert property (@(posedge CLK) disable iff (RST) lock_vld_q |-> ((gnt & ~own) == '0));
endmodule

// File: tb/tb_m_matrix_arbiter_pkt_lock.sv
// tb_m_matrix_arbiter_pkt_lock: scoreboard bench; reference keeps priority as an ordered list of ports.
module tb_m_matrix_arbiter_pkt_lock;
    localparam int N    = 5;
    localparam int ID_W = 3;

    typedef struct {
        logic [N-1:0]    g;
        logic [ID_W-1:0] id;
        logic            lk;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    tail = '0;
    logic            en = 1'b0;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic            locked;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    int order[$];
    bit m_lv;
    int m_lid;

    m_matrix_arbiter_pkt_lock #(.N(N), .ID_W(ID_W)) dut (
        .CLK(CLK), .RST(RST), .req(req), .tail(tail), .en(en),
        .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .locked(locked)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        order = {};
        for (int i = 0; i < N; i++) order.push_back(i);
        m_lv = 0;
        m_lid = 0;
    endtask

    // Drive one cycle, predict its outputs, then advance the reference to the next edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic e, input logic rs);
        exp_t x;
        int k;
        @(posedge CLK);
        #1;
        req = r; tail = t; en = e; RST = rs;
        k = -1;
        if (!rs) begin
            if (m_lv) begin
                if (r[m_lid] && e) k = m_lid;
            end else if (e) begin
                foreach (order[p])
                    if (k < 0 && r[order[p]]) k = order[p];
            end
        end
        x.g  = (k >= 0) ? N'(1) << k : '0;
        x.id = (k >= 0) ? ID_W'(k) : '0;
        x.lk = m_lv;
        sb.push_back(x);
        if (rs) model_reset();
        else if (k >= 0) begin
            if (t[k]) begin
                m_lv = 0;
                foreach (order[p])
                    if (order[p] == k) begin order.delete(p); break; end
                order.push_back(k);
            end else begin
                m_lv = 1;
                m_lid = k;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("gnt", 32'(gnt), 32'(x.g));
            chk("gnt_id", 32'(gnt_id), 32'(x.id));
            chk("gnt_vld", 32'(gnt_vld), 32'(|x.g));
            chk("locked", 32'(locked), 32'(x.lk));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        step('0, '0, 1'b0, 1'b1);
        // Directed: reset priority, round robin, lock hold, bubble, en stall, reset mid-packet
        step(5'b10110, '1, 1'b1, 1'b0);
        step(5'b10110, '1, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step('1, '1, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        step(5'b00100, 5'b00000, 1'b1, 1'b0);
        step(5'b00101, 5'b00000, 1'b1, 1'b0);
        step(5'b00101, 5'b00100, 1'b1, 1'b0);
        step(5'b00001, 5'b00001, 1'b1, 1'b0);
        step(5'b00010, 5'b00000, 1'b1, 1'b0);
        step(5'b01000, 5'b00000, 1'b1, 1'b0);
        step(5'b01000, 5'b00000, 1'b1, 1'b0);
        step(5'b01010, 5'b00010, 1'b1, 1'b0);
        step(5'b01000, 5'b01000, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b00011, '1, 1'b0, 1'b0);
        step(5'b00011, '1, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(5'b10000, 5'b00001, 1'b1, 1'b0);
        step(5'b10000, 5'b00000, 1'b1, 1'b0);
        step(5'b10001, 5'b00000, 1'b1, 1'b1);
        step(5'b10001, '1, 1'b1, 1'b0);
        // Randomized traffic with occasional stalls and resets
        for (int c = 0; c < 2000; c++)
            step(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 199) == 0));
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge CLK);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
